// File: rtl/sqrt_unit.sv
// sqrt_unit: iterative restoring integer square root.
// Produces floor(sqrt(DATA_IN)) and its remainder, one root bit per clock.
// Handshake: EN_Sqrt starts and holds a request, RST_Sqrt is a soft abort,
// RDY_Sqrt flags a result that stays readable after the handshake ends.
module sqrt_unit #(
  parameter  int IN_WIDTH  = 32,
  localparam int OUT_WIDTH = IN_WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 RST_N,
  input  logic                 RST_Sqrt,
  input  logic                 EN_Sqrt,
  input  logic [IN_WIDTH-1:0]  DATA_IN,
  output logic                 RDY_Sqrt,
  output logic [OUT_WIDTH-1:0] SQRT_OUT,
  output logic [OUT_WIDTH:0]   REM_OUT
);

  localparam int CNT_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int RW    = OUT_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  rad_q, rad_d;
  // The partial remainder never exceeds 2*root, so OUT_WIDTH+1 bits hold it
  // exactly; the trial compare below still runs at the full OUT_WIDTH+2 bits.
  logic [OUT_WIDTH:0]   rem_q, rem_d;
  logic [OUT_WIDTH-1:0] root_q, root_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] sqrt_q, sqrt_d;
  logic [OUT_WIDTH:0]   remo_q, remo_d;
  logic                 rdy_q, rdy_d;

  logic [RW-1:0]        r_prime;
  logic [RW-1:0]        trial;
  logic                 ge;
  logic [OUT_WIDTH:0]   diff;

  // One restoring step: bring down the next two radicand bits and try 4*root+1.
  // When r_prime >= trial the true difference fits OUT_WIDTH+1 bits, so the
  // truncated subtraction is exact.
  assign r_prime = {rem_q[OUT_WIDTH-1:0], rad_q[IN_WIDTH-1 -: 2]};
  assign trial   = {root_q, 2'b01};
  assign ge      = (r_prime >= trial);
  assign diff    = r_prime[OUT_WIDTH:0] - trial[OUT_WIDTH:0];

  // State register; RST_N clears asynchronously.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the soft reset overrides every request.
  always_comb begin
    state_d = state_q;
    if (RST_Sqrt) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (EN_Sqrt) state_d = S_ITER;
        S_ITER: begin
          if (!EN_Sqrt)           state_d = S_IDLE;
          else if (cnt_q == '0)   state_d = S_DONE;
        end
        S_DONE:  if (!EN_Sqrt) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values; results only move on the final step.
  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    sqrt_d = sqrt_q;
    remo_d = remo_q;
    rdy_d  = rdy_q;
    if (RST_Sqrt) begin
      rdy_d = 1'b0;
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (EN_Sqrt) begin
            rad_d  = DATA_IN;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CNT_W'(OUT_WIDTH - 1);
          end
        end
        S_ITER: begin
          if (EN_Sqrt) begin
            rad_d = rad_q << 2;
            if (ge) begin
              rem_d  = diff;
              root_d = {root_q[OUT_WIDTH-2:0], 1'b1};
            end else begin
              rem_d  = r_prime[OUT_WIDTH:0];
              root_d = {root_q[OUT_WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
              sqrt_d = root_d;
              remo_d = rem_d;
              rdy_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (!EN_Sqrt) rdy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers; RST_N clears everything asynchronously.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      sqrt_q <= '0;
      remo_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      sqrt_q <= sqrt_d;
      remo_q <= remo_d;
      rdy_q  <= rdy_d;
    end
  end

  assign RDY_Sqrt = rdy_q;
  assign SQRT_OUT = sqrt_q;
  assign REM_OUT  = remo_q;

endmodule

// File: tb/tb_sqrt_unit.sv
// tb_sqrt_unit: scoreboard bench for sqrt_unit (IN_WIDTH = 32).
// Stimulus acts like the control unit (drives on the falling edge); a monitor
// pops expected results whenever RDY_Sqrt rises.
module tb_sqrt_unit;

  logic        clk;
  logic        RST_N;
  logic        RST_Sqrt;
  logic        EN_Sqrt;
  logic [31:0] DATA_IN;
  logic        RDY_Sqrt;
  logic [15:0] SQRT_OUT;
  logic [16:0] REM_OUT;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d;
    logic [15:0] s;
    logic [16:0] r;
  } exp_t;

  exp_t exp_q[$];

  sqrt_unit #(.IN_WIDTH(32)) dut (
    .clk      (clk),
    .RST_N    (RST_N),
    .RST_Sqrt (RST_Sqrt),
    .EN_Sqrt  (EN_Sqrt),
    .DATA_IN  (DATA_IN),
    .RDY_Sqrt (RDY_Sqrt),
    .SQRT_OUT (SQRT_OUT),
    .REM_OUT  (REM_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: largest s with s*s <= d, found by bisection on plain integers.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] d);
    longint dd, lo, hi, mid;
    dd = d;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= dd) lo = mid;
      else                 hi = mid;
    end
    return lo[15:0];
  endfunction

  // Monitor: every rising RDY_Sqrt must match the oldest outstanding request.
  bit prev_rdy = 1'b0;
  always @(negedge clk) begin
    exp_t   e;
    longint s, r;
    if (RDY_Sqrt === 1'b1 && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rdy: got result %0h/%0h, required no result", SQRT_OUT, REM_OUT);
      end else begin
        e = exp_q.pop_front();
        s = SQRT_OUT;
        r = REM_OUT;
        chk("sqrt", s, e.s);
        chk("rem", r, e.r);
        chk("identity", s * s + r, e.d);
        chk("rem_bound", (r <= 2 * s) ? 1 : 0, 1);
      end
    end
    prev_rdy = (RDY_Sqrt === 1'b1);
  end

  // Start a request at a falling edge; optionally disturb DATA_IN mid-run.
  task automatic run_op(input logic [31:0] d, input bit scribble);
    exp_t e;
    int   cyc;
    e.d = d;
    e.s = ref_sqrt(d);
    e.r = 17'(longint'(d) - longint'(e.s) * longint'(e.s));
    exp_q.push_back(e);
    DATA_IN = d;
    EN_Sqrt = 1'b1;
    cyc = 0;
    while (RDY_Sqrt !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (scribble && cyc == 3) DATA_IN = $urandom;
    end
    // 17 rising edges including the one that loads the radicand.
    chk("latency", cyc, 17);
  endtask

  task automatic drop_en();
    EN_Sqrt = 1'b0;
    @(negedge clk);
    chk("rdy_drop", RDY_Sqrt, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] k;
    int          hold;
    int          sel;
    int          wait_cyc;

    RST_N    = 1'b0;
    RST_Sqrt = 1'b0;
    EN_Sqrt  = 1'b0;
    DATA_IN  = '0;
    repeat (2) @(negedge clk);
    chk("reset_rdy", RDY_Sqrt, 0);
    chk("reset_sqrt", SQRT_OUT, 0);
    chk("reset_rem", REM_OUT, 0);
    RST_N = 1'b1;
    @(negedge clk);

    // Zero radicand
    run_op(32'd0, 1'b0);
    chk("zero_sqrt", SQRT_OUT, 0);
    chk("zero_rem", REM_OUT, 0);
    drop_en();

    // Maximum radicand
    run_op(32'hFFFF_FFFF, 1'b0);
    chk("max_sqrt", SQRT_OUT, 16'hFFFF);
    chk("max_rem", REM_OUT, 17'h1FFFE);
    drop_en();

    // Exact square
    run_op(32'd1000000, 1'b0);
    chk("sq_sqrt", SQRT_OUT, 1000);
    chk("sq_rem", REM_OUT, 0);
    drop_en();

    // Non-square, hold, drop, soft reset preserve
    run_op(32'd99, 1'b0);
    chk("n99_sqrt", SQRT_OUT, 9);
    chk("n99_rem", REM_OUT, 18);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rdy", RDY_Sqrt, 1);
    end
    drop_en();
    chk("keep_sqrt", SQRT_OUT, 9);
    RST_Sqrt = 1'b1;
    @(negedge clk);
    RST_Sqrt = 1'b0;
    chk("srst_sqrt", SQRT_OUT, 9);
    chk("srst_rem", REM_OUT, 18);
    chk("srst_rdy", RDY_Sqrt, 0);
    @(negedge clk);

    // Abort after 8 cycles: no result, outputs untouched
    DATA_IN = 32'd50;
    EN_Sqrt = 1'b1;
    repeat (8) @(negedge clk);
    EN_Sqrt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_rdy", RDY_Sqrt, 0);
    end
    chk("abort_sqrt", SQRT_OUT, 9);
    run_op(32'd50, 1'b0);
    chk("n50_sqrt", SQRT_OUT, 7);
    chk("n50_rem", REM_OUT, 1);
    drop_en();

    // Soft reset wins over EN_Sqrt
    RST_Sqrt = 1'b1;
    EN_Sqrt  = 1'b1;
    DATA_IN  = 32'd12345;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("prio_rdy", RDY_Sqrt, 0);
    end
    RST_Sqrt = 1'b0;
    EN_Sqrt  = 1'b0;
    @(negedge clk);
    chk("prio_sqrt", SQRT_OUT, 7);

    // DATA_IN changes during iteration are ignored
    run_op(32'd123456789, 1'b1);
    chk("scrib_sqrt", SQRT_OUT, 11111);
    chk("scrib_rem", REM_OUT, 2468);
    drop_en();

    // Asynchronous reset mid-iteration
    DATA_IN = 32'd777;
    EN_Sqrt = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_rdy", RDY_Sqrt, 0);
    chk("arst_sqrt", SQRT_OUT, 0);
    chk("arst_rem", REM_OUT, 0);
    EN_Sqrt = 1'b0;
    @(negedge clk);
    RST_N = 1'b1;
    @(negedge clk);
    run_op(32'd144, 1'b0);
    chk("n144_sqrt", SQRT_OUT, 12);
    chk("n144_rem", REM_OUT, 0);
    drop_en();

    // Randomized handshakes
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 3);
      k   = 16'($urandom);
      case (sel)
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 1000));
        2:       d = 32'(k) * 32'(k);
        default: d = 32'(k) * 32'(k) + 32'(k) * 2;
      endcase
      run_op(d, ($urandom_range(0, 3) == 0));
      hold = $urandom_range(0, 2);
      repeat (hold) @(negedge clk);
      drop_en();
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
